// File: rtl/sync_updown_counter.sv
// Fully synchronous up/down counter with modulus MAX_VAL+1, parallel load,
// count enable, wrap or saturate at the limits, and tc/ovf/unf/sat indications.
module sync_updown_counter #(
  parameter int unsigned         WIDTH    = 4,
  parameter logic [WIDTH-1:0]    MAX_VAL  = '1,
  parameter bit                  SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             m,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             sat
);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q_next;
  logic             ovf_next;
  logic             unf_next;
  logic             sat_next;

  assign at_max  = (q == MAX_VAL);
  assign at_zero = (q == '0);
  assign tc      = (m & at_max) | (~m & at_zero);

  // A full-range modulus can never see an out-of-range load value.
  generate
    if (MAX_VAL == '1) begin : g_no_clamp
      assign load_val = d;
    end else begin : g_clamp
      assign load_val = (d > MAX_VAL) ? MAX_VAL : d;
    end
  endgenerate

  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    sat_next = 1'b0;
    if (ld) begin
      q_next = load_val;
    end else if (en) begin
      if (m) begin
        if (!at_max) begin
          q_next = q + WIDTH'(1);
        end else if (SATURATE) begin
          sat_next = 1'b1;
        end else begin
          q_next   = '0;
          ovf_next = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_next = q - WIDTH'(1);
        end else if (SATURATE) begin
          sat_next = 1'b1;
        end else begin
          q_next   = MAX_VAL;
          unf_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      q   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      sat <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
      unf <= unf_next;
      sat <= sat_next;
    end
  end

endmodule

// File: tb/tb_sync_updown_counter.sv
// Drives a decade wrap-mode counter and a 4-bit saturating counter with shared
// stimulus; expected outputs are queued at drive time and popped after each edge.
module tb_sync_updown_counter;

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       en  = 1'b0;
  logic       m   = 1'b0;
  logic       ld  = 1'b0;
  logic [3:0] d   = '0;

  logic [3:0] qa, qb;
  logic       tca, ovfa, unfa, sata;
  logic       tcb, ovfb, unfb, satb;

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dec (
    .clk(clk), .res(res), .en(en), .m(m), .ld(ld), .d(d),
    .q(qa), .tc(tca), .ovf(ovfa), .unf(unfa), .sat(sata)
  );

  sync_updown_counter #(.WIDTH(4), .MAX_VAL(4'd15), .SATURATE(1'b1)) u_sat (
    .clk(clk), .res(res), .en(en), .m(m), .ld(ld), .d(d),
    .q(qb), .tc(tcb), .ovf(ovfb), .unf(unfb), .sat(satb)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [13:0] sb[$];
  logic [13:0] obs, exp_v;
  logic        exp_tca, exp_tcb;
  int unsigned mqa = 0, mqb = 0;

  // Reference behaviour: returns {q[3:0], ovf, unf, sat} after one edge.
  function automatic logic [6:0] model(input int unsigned q, input int unsigned mx,
                                       input bit satm, input logic r, input logic l,
                                       input logic [3:0] dv, input logic e, input logic mm);
    int unsigned nq = q;
    logic o = 1'b0, u = 1'b0, s = 1'b0;
    if (r) nq = 0;
    else if (l) nq = (int'(dv) > mx) ? mx : int'(dv);
    else if (e) begin
      if (mm) begin
        if (q < mx) nq = q + 1;
        else if (satm) s = 1'b1;
        else begin nq = 0; o = 1'b1; end
      end else begin
        if (q > 0) nq = q - 1;
        else if (satm) s = 1'b1;
        else begin nq = mx; u = 1'b1; end
      end
    end
    return {nq[3:0], o, u, s};
  endfunction

  task automatic drive(input logic r, input logic l, input logic [3:0] dv,
                       input logic e, input logic mm);
    logic [6:0] ra, rb;
    res = r; ld = l; d = dv; en = e; m = mm;
    exp_tca = (mm && mqa == 9) || (!mm && mqa == 0);
    exp_tcb = (mm && mqb == 15) || (!mm && mqb == 0);
    ra = model(mqa, 9, 1'b0, r, l, dv, e, mm);
    rb = model(mqb, 15, 1'b1, r, l, dv, e, mm);
    mqa = ra[6:3];
    mqb = rb[6:3];
    sb.push_back({ra, rb});
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    tick();
    obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_state: got %h want %h", obs, exp_v); end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({tca, tcb} !== 2'b11) begin n_err++; $display("FAIL reset_tc: got %b want 11", {tca, tcb}); end
    tick();
    obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_hold: got %h want %h", obs, exp_v); end
  endtask

  task automatic test_decade_wrap;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      n_cmp++;
      if ({tca, tcb} !== {exp_tca, exp_tcb}) begin
        n_err++; $display("FAIL decade_tc[%0d]: got %b want %b", i, {tca, tcb}, {exp_tca, exp_tcb});
      end
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL decade_q[%0d]: got %h want %h", i, obs, exp_v); end
    end
    n_cmp++;
    if ({qa, ovfa} !== 5'b0000_1) begin n_err++; $display("FAIL decade_ovf: got %b want 00001", {qa, ovfa}); end
  endtask

  task automatic test_down_wrap;
    drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    tick();
    obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
    exp_v = sb.pop_front();
    n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL down_load: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL down_wrap[%0d]: got %h want %h", i, obs, exp_v); end
    end
    n_cmp++;
    if ({qa, unfa} !== 5'b1000_0) begin n_err++; $display("FAIL down_after: got %b want 10000", {qa, unfa}); end
  endtask

  task automatic test_saturate;
    logic [3:0] ld_vals [2] = '{4'd14, 4'd1};
    logic       dirs    [2] = '{1'b1, 1'b0};
    int         steps   [2] = '{3, 2};
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, ld_vals[k], 1'b0, dirs[k]);
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL sat_load[%0d]: got %h want %h", k, obs, exp_v); end
      for (int i = 0; i < steps[k]; i++) begin
        drive(1'b0, 1'b0, 4'd0, 1'b1, dirs[k]);
        tick();
        obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL sat_step[%0d.%0d]: got %h want %h", k, i, obs, exp_v); end
      end
    end
    n_cmp++;
    if ({qb, satb} !== 5'b0000_1) begin n_err++; $display("FAIL sat_floor: got %b want 00001", {qb, satb}); end
  endtask

  task automatic test_priority;
    logic r_v [3] = '{1'b0, 1'b0, 1'b1};
    logic l_v [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(r_v[i], l_v[i], 4'd13, 1'b1, 1'b1);
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL priority[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  task automatic test_reversal;
    drive(1'b0, 1'b1, 4'd5, 1'b0, 1'b1);
    tick();
    void'(sb.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1, (i % 2) == 0);
      n_cmp++;
      if ({tca, tcb} !== {exp_tca, exp_tcb}) begin
        n_err++; $display("FAIL rev_tc[%0d]: got %b want %b", i, {tca, tcb}, {exp_tca, exp_tcb});
      end
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL rev_q[%0d]: got %h want %h", i, obs, exp_v); end
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        drive(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
        tick();
        obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
        exp_v = sb.pop_front();
        n_cmp++;
        if (obs !== exp_v) begin n_err++; $display("FAIL rev_hold[%0d.%0d]: got %h want %h", i, g, obs, exp_v); end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      n_cmp++;
      if ({tca, tcb} !== {exp_tca, exp_tcb}) begin
        n_err++; $display("FAIL b2b_tc[%0d]: got %b want %b", i, {tca, tcb}, {exp_tca, exp_tcb});
      end
      tick();
      obs = {qa, ovfa, unfa, sata, qb, ovfb, unfb, satb};
      exp_v = sb.pop_front();
      n_cmp++;
      if (obs !== exp_v) begin n_err++; $display("FAIL b2b_q[%0d]: got %h want %h", i, obs, exp_v); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_decade_wrap();
    test_down_wrap();
    test_saturate();
    test_priority();
    test_reversal();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_updown_counter.md
# sync_updown_counter

Parametrised, fully synchronous up/down counter; the single-clock successor to the team's 4-bit asynchronous ripple up/down counter. It adds programmable width and modulus, parallel load, count enable, and a selectable wrap or saturate mode. It also provides terminal-count, overflow and underflow indications. Used wherever a counter must sit in the main clock domain without ripple skew, e.g. timers, decade counters, and FIFO/credit tracking.

## Interface
- WIDTH, 4: counter width in bits; legal range 1..32.
- MAX_VAL, 2**WIDTH-1: highest count value (modulus = MAX_VAL+1); legal range 1..2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.

- clk  input  1  clock; all state changes on the rising edge.
- res  input  1  reset, synchronous, active-high.
- en  input  1  count enable.
- m  input  1  direction: 1 = up, 0 = down.
- ld  input  1  parallel load strobe.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational from q and m).
- ovf  output  1  one-cycle pulse: an up-count wrapped MAX_VAL→0 (registered).
- unf  output  1  one-cycle pulse: a down-count wrapped 0→MAX_VAL (registered).
- sat  output  1  one-cycle pulse: a count was blocked at a limit in saturate mode (registered).

## Operation
- Priority on each rising clk edge: res > ld > en. With none asserted, q holds and all pulses are 0.
- res=1: q=0, ovf=0, unf=0, sat=0. Takes effect only at the edge. A mid-count res overrides ld and en in the same cycle.
- ld=1 (res=0):
  - If d ≤ MAX_VAL, q ← d.
  - If d > MAX_VAL, q ← MAX_VAL (clamped).
  - ovf, unf and sat are all 0, regardless of en and m.
- en=1, ld=0, m=1 (up):
  - q < MAX_VAL: q ← q+1.
  - q == MAX_VAL and SATURATE=0: q ← 0, ovf=1.
  - q == MAX_VAL and SATURATE=1: q holds, sat=1.
- en=1, ld=0, m=0 (down):
  - q > 0: q ← q−1.
  - q == 0 and SATURATE=0: q ← MAX_VAL, unf=1.
  - q == 0 and SATURATE=1: q holds, sat=1.
- Arithmetic is modulo MAX_VAL+1, not modulo 2**WIDTH. q never exceeds MAX_VAL after any edge.
- tc = (m & q==MAX_VAL) | (~m & q==0).
  - tc is independent of en; it means "the next enabled step hits a limit".
  - tc follows m combinationally.
- The direction input m may change on any cycle. The new direction applies at the next edge with en=1. No extra cycle is lost on reversal.
- ovf, unf and sat are mutually exclusive. At most one is high in any cycle.

## Timing
- Latency: q updates one cycle after ld or en is sampled high. ovf/unf/sat are asserted in the same cycle that the wrapping or blocked q value appears.
- Every pulse lasts exactly one cycle. Continuous en at a limit in saturate mode gives sat=1 on every enabled cycle.
- Throughput: one step per clock while en=1.
- Reset values: q=0, ovf=0, unf=0, sat=0. tc after reset = ~m (q=0).
- tc has a combinational path from m to tc. All other outputs are flop outputs.
- No asynchronous paths. The block has no clock derived from q (unlike the ripple predecessor).

## Test plan
- Reset: drive res=1 with en=1, m=1, ld=1, d=5 → after the edge q=0 and ovf=unf=sat=0. Then with m=0: tc=1.
- Decade wrap (WIDTH=4, MAX_VAL=9, SATURATE=0): up-count 10 enabled cycles from 0 → q goes 1..9 then 0. ovf=1 only in the cycle q=0 appears. tc=1 while q=9.
- Down wrap (same parameters): load d=0, then m=0, en=1 → q=9 and unf=1 for one cycle, then q=8 with unf=0.
- Saturate (WIDTH=4, MAX_VAL=15, SATURATE=1):
  - Load 14, up ×3 → q goes 15, 15, 15, with sat=1 on the 2nd and 3rd cycles and ovf never set.
  - Load 1, down ×2 → q goes 0 then 0, with sat=1 on the 2nd cycle.
- Priority and clamp (MAX_VAL=9): hold en=1, m=1 and pulse ld=1 with d=13 → q=9 (clamped), no pulse. On the next cycle with en=1 → q=0, ovf=1. Asserting res in the same cycle as ld → q=0.
- Direction reversal: from q=5, toggle m every cycle with en=1 → q goes 6, 5, 6, 5. tc stays 0. Throughout, en=0 for a random number of cycles holds q.
